// File: rtl/seg_timer_pkg.sv
// rtl/seg_timer_pkg.sv - shared types and constants for the segmented timer bank
//   tmr_state_t : per-channel state (IDLE, RUN, DONE)
//   CNT_W_DEF   : default counter / terminal-count width
//   TERM_*      : standard terminal counts at 50 MHz
package seg_timer_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } tmr_state_t;

  localparam int CNT_W_DEF  = 26;

  localparam int TERM_1S34  = 67_000_000;
  localparam int TERM_10MS  = 500_000;
  localparam int TERM_1MS   = 50_000;

endpackage

// File: rtl/seg_timer_ch.sv
// rtl/seg_timer_ch.sv - one timer channel: effective terminal, counter, state, expiry
//   Optional macro: SEG_TIMER_WARN_EN adds the registered warn output.
//   clk, rst_n : clock, asynchronous active-low reset
//   en         : run enable, low pauses the channel
//   clr        : synchronous clear, overrides everything else
//   periodic   : 0 = one-shot (sticky full), 1 = periodic tick
//   term       : raw terminal count
//   full       : one-shot expired, held until clr
//   tick       : one-cycle pulse on each expiry
//   warn       : pre-expiry warning (SEG_TIMER_WARN_EN only)
module seg_timer_ch
  import seg_timer_pkg::*;
#(
  parameter int CNT_W      = CNT_W_DEF,
  parameter int FAST_SIM   = 0,
  parameter int FAST_SHIFT = 11
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             clr,
  input  logic             periodic,
  input  logic [CNT_W-1:0] term,
  output logic             full,
  output logic             tick
`ifdef SEG_TIMER_WARN_EN
  ,
  output logic             warn
`endif
);

  tmr_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             full_d, tick_d;

  logic [CNT_W-1:0] t_raw, t_eff, t_m1;

  // A zero terminal would never expire; the shortest meaningful period is 1.
  assign t_raw = (FAST_SIM != 0) ? (term >> FAST_SHIFT) : term;
  assign t_eff = (t_raw == '0) ? CNT_W'(1) : t_raw;
  assign t_m1  = t_eff - CNT_W'(1);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    full_d  = full;
    tick_d  = 1'b0;
    if (clr) begin
      cnt_d   = '0;
      full_d  = 1'b0;
      state_d = en ? RUN : IDLE;
    end else begin
      case (state_q)
        // IDLE is a pause: the edge on which en returns already counts, so a
        // pause of N low cycles delays expiry by exactly N.
        IDLE, RUN: begin
          if (en) begin
            state_d = RUN;
            // >= so that lowering term below the current count expires at
            // once instead of wrapping through the full counter range.
            if (cnt_q >= t_m1) begin
              tick_d = 1'b1;
              if (periodic) begin
                cnt_d = '0;
              end else begin
                cnt_d   = t_eff;
                full_d  = 1'b1;
                state_d = DONE;
              end
            end else begin
              cnt_d = cnt_q + CNT_W'(1);
            end
          end else begin
            state_d = IDLE;
          end
        end
        DONE:    state_d = DONE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      full    <= 1'b0;
      tick    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      full    <= full_d;
      tick    <= tick_d;
    end
  end

`ifdef SEG_TIMER_WARN_EN
  logic [CNT_W-1:0] t_warn;
  logic             warn_d;

  // Warn covers the last quarter of a one-shot run; computed from the next
  // state so the registered output drops on the expiry edge itself.
  assign t_warn = t_eff - (t_eff >> 2);
  assign warn_d = (state_d == RUN) && !periodic && (cnt_d >= t_warn);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      warn <= 1'b0;
    end else begin
      warn <= warn_d;
    end
  end
`endif

endmodule

// File: rtl/seg_timer_bank.sv
// rtl/seg_timer_bank.sv - bank of NUM_CH independent programmable interval timers
//   Optional macro: SEG_TIMER_WARN_EN adds the warn output vector.
//   clk, rst_n : clock, asynchronous active-low reset
//   en         : per-channel run enable
//   clr        : per-channel synchronous clear (highest priority)
//   periodic   : per-channel mode, 0 = one-shot, 1 = periodic
//   term       : packed terminal counts, channel i at term[i*CNT_W +: CNT_W]
//   full       : per-channel sticky one-shot expiry
//   tick       : per-channel one-cycle expiry pulse
//   warn       : per-channel pre-expiry warning (SEG_TIMER_WARN_EN only)
module seg_timer_bank
  import seg_timer_pkg::*;
#(
  parameter int NUM_CH     = 4,
  parameter int CNT_W      = CNT_W_DEF,
  parameter int FAST_SIM   = 0,
  parameter int FAST_SHIFT = 11
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_CH-1:0]       en,
  input  logic [NUM_CH-1:0]       clr,
  input  logic [NUM_CH-1:0]       periodic,
  input  logic [NUM_CH*CNT_W-1:0] term,
  output logic [NUM_CH-1:0]       full,
  output logic [NUM_CH-1:0]       tick
`ifdef SEG_TIMER_WARN_EN
  ,
  output logic [NUM_CH-1:0]       warn
`endif
);

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    seg_timer_ch #(
      .CNT_W      (CNT_W),
      .FAST_SIM   (FAST_SIM),
      .FAST_SHIFT (FAST_SHIFT)
    ) u_ch (
      .clk      (clk),
      .rst_n    (rst_n),
      .en       (en[i]),
      .clr      (clr[i]),
      .periodic (periodic[i]),
      .term     (term[i*CNT_W +: CNT_W]),
      .full     (full[i]),
      .tick     (tick[i])
`ifdef SEG_TIMER_WARN_EN
      ,
      .warn     (warn[i])
`endif
    );
  end

endmodule

// File: tb/tb_seg_timer_bank.sv
// tb/tb_seg_timer_bank.sv - scoreboard testbench for seg_timer_bank
module tb_seg_timer_bank;

  localparam int NCH  = 4;
  localparam int CW   = 26;
  localparam int NALL = NCH + 1;  // channel index NCH is the FAST_SIM instance

  logic              clk   = 1'b0;
  logic              rst_n = 1'b0;
  logic [NCH-1:0]    en    = '0;
  logic [NCH-1:0]    clr   = '0;
  logic [NCH-1:0]    periodic = '0;
  logic [NCH*CW-1:0] term  = '0;
  logic [NCH-1:0]    full, tick;

  logic [0:0]        f_en  = '0;
  logic [0:0]        f_clr = '0;
  logic [0:0]        f_per = '0;
  logic [CW-1:0]     f_term = '0;
  logic [0:0]        f_full, f_tick;

`ifdef SEG_TIMER_WARN_EN
  logic [NCH-1:0]    warn;
  logic [0:0]        f_warn;
`endif

  always #5 clk = ~clk;

  seg_timer_bank #(.NUM_CH(NCH), .CNT_W(CW), .FAST_SIM(0), .FAST_SHIFT(11)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .periodic(periodic), .term(term),
    .full(full), .tick(tick)
`ifdef SEG_TIMER_WARN_EN
    , .warn(warn)
`endif
  );

  seg_timer_bank #(.NUM_CH(1), .CNT_W(CW), .FAST_SIM(1), .FAST_SHIFT(11)) dut_fast (
    .clk(clk), .rst_n(rst_n), .en(f_en), .clr(f_clr), .periodic(f_per), .term(f_term),
    .full(f_full), .tick(f_tick)
`ifdef SEG_TIMER_WARN_EN
    , .warn(f_warn)
`endif
  );

  int n_tests = 0;
  int n_fail  = 0;
  int edges   = 0;

  always @(posedge clk) edges <= edges + 1;

  // Scoreboard: expected tick edge numbers and full level at that tick.
  int exp_q[NALL][$];
  bit exp_full[NALL][$];

  logic [NALL-1:0] all_tick, all_full;
  logic [NALL-1:0] prev_full = '0;
  assign all_tick = {f_tick, tick};
  assign all_full = {f_full, full};

  always @(negedge clk) begin
    int e;
    bit f;
    for (int c = 0; c < NALL; c++) begin
      while (exp_q[c].size() > 0 && exp_q[c][0] < edges) begin
        n_tests++;
        n_fail++;
        $display("FAIL tick_missing ch%0d: no tick seen, expected at edge %0d (now %0d)",
                 c, exp_q[c][0], edges);
        void'(exp_q[c].pop_front());
        void'(exp_full[c].pop_front());
      end
      if (all_tick[c]) begin
        n_tests++;
        if (exp_q[c].size() == 0) begin
          n_fail++;
          $display("FAIL tick_unexpected ch%0d: tick at edge %0d, none expected", c, edges);
        end else begin
          e = exp_q[c].pop_front();
          f = exp_full[c].pop_front();
          if (e != edges || all_full[c] != f) begin
            n_fail++;
            $display("FAIL tick_check ch%0d: got tick at edge %0d full=%0b, expected edge %0d full=%0b",
                     c, edges, all_full[c], e, f);
          end
        end
      end else if (all_full[c] && !prev_full[c]) begin
        n_tests++;
        n_fail++;
        $display("FAIL full_rise ch%0d: full rose at edge %0d without tick", c, edges);
      end
    end
    prev_full = all_full;
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check(input string nm, input longint act, input longint exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic expect_tick(input int c, input int e, input bit f);
    exp_q[c].push_back(e);
    exp_full[c].push_back(f);
  endtask

  task automatic drain(input string nm);
    for (int c = 0; c < NALL; c++) begin
      check(nm, exp_q[c].size(), 0);
      exp_q[c].delete();
      exp_full[c].delete();
    end
  endtask

  task automatic set_term(input int ch, input int v);
    term[ch*CW +: CW] = CW'(v);
  endtask

  // clr and en together: the clr edge is edge e0, counting starts after it.
  task automatic start0(input int tv, input bit per, output int e0);
    set_term(0, tv);
    periodic[0] = per;
    en[0]  = 1'b1;
    clr[0] = 1'b1;
    e0 = edges + 1;
    step(1);
    clr[0] = 1'b0;
  endtask

  task automatic stop0();
    en[0]  = 1'b0;
    clr[0] = 1'b1;
    step(1);
    clr[0] = 1'b0;
  endtask

  initial begin
    int e0, tv, te, c, l, nt, ft;

    // reset state
    step(3);
    check("reset_full", full, 0);
    check("reset_tick", tick, 0);
    check("reset_fast_full", f_full, 0);
    rst_n = 1'b1;
    step(3);
    check("idle_full", full, 0);
    check("idle_tick", tick, 0);

    // one-shot: expiry after T edges, full held, cleared by clr
    for (int it = 0; it < 4; it++) begin
      tv = (it == 0) ? 10 : ((it == 1) ? 0 : int'($urandom_range(2, 40)));
      te = (tv == 0) ? 1 : tv;
      start0(tv, 1'b0, e0);
      expect_tick(0, e0 + te, 1'b1);
      step(te);
      check("oneshot_full_rise", full[0], 1);
      step(50);
      check("oneshot_full_hold", full[0], 1);
      check("oneshot_tick_low", tick[0], 0);
      stop0();
      check("oneshot_full_clr", full[0], 0);
    end
    drain("drain_oneshot");

    // periodic: tick every T enabled edges, never full
    for (int it = 0; it < 4; it++) begin
      tv = (it == 0) ? 5 : ((it == 1) ? 0 : int'($urandom_range(2, 12)));
      te = (tv == 0) ? 1 : tv;
      start0(tv, 1'b1, e0);
      for (int k = 1; k <= 4; k++) expect_tick(0, e0 + k * te, 1'b0);
      step(4 * te);
      check("periodic_full_low", full[0], 0);
      stop0();
    end
    drain("drain_periodic");

    // pause: en low for L edges delays expiry by L
    for (int it = 0; it < 4; it++) begin
      if (it == 0) begin te = 20; c = 8; l = 7; end
      else begin
        te = $urandom_range(10, 40);
        c  = $urandom_range(1, te - 2);
        l  = $urandom_range(1, 15);
      end
      start0(te, 1'b0, e0);
      step(c);
      en[0] = 1'b0;
      step(l);
      en[0] = 1'b1;
      expect_tick(0, e0 + te + l, 1'b1);
      step(te - c);
      check("pause_full", full[0], 1);
      stop0();
    end
    drain("drain_pause");

    // shrink term below the current count: expiry on the next enabled edge
    for (int it = 0; it < 4; it++) begin
      if (it == 0) begin te = 20; c = 12; nt = 6; end
      else begin
        te = $urandom_range(15, 40);
        c  = $urandom_range(2, te - 2);
        nt = $urandom_range(1, c);
      end
      start0(te, 1'b0, e0);
      step(c);
      set_term(0, nt);
      expect_tick(0, e0 + c + 1, 1'b1);
      step(2);
      check("shrink_full", full[0], 1);
      stop0();
    end
    drain("drain_shrink");

    // clr in the expiry cycle wins: no tick, counter restarts from 0
    for (int it = 0; it < 3; it++) begin
      te = $urandom_range(3, 20);
      start0(te, 1'b0, e0);
      step(te - 1);
      clr[0] = 1'b1;
      step(1);
      clr[0] = 1'b0;
      check("prio_full_low", full[0], 0);
      expect_tick(0, e0 + 2 * te, 1'b1);
      step(te);
      check("prio_full_late", full[0], 1);
      stop0();
    end
    drain("drain_prio");

    // fast-sim instance: terminal compressed by 2048
    for (int it = 0; it < 3; it++) begin
      ft = (it == 0) ? 67_000_000 : ((it == 1) ? 100 : int'($urandom_range(2048, 200000)));
      te = ft / 2048;
      if (te == 0) te = 1;
      f_term = CW'(ft);
      f_per  = 1'b0;
      f_en   = 1'b1;
      f_clr  = 1'b1;
      e0 = edges + 1;
      step(1);
      f_clr = 1'b0;
      expect_tick(NCH, e0 + te, 1'b1);
      step(te);
      check("fast_full", f_full, 1);
      f_en  = 1'b0;
      f_clr = 1'b1;
      step(1);
      f_clr = 1'b0;
      check("fast_full_clr", f_full, 0);
    end
    drain("drain_fast");

`ifdef SEG_TIMER_WARN_EN
    // warn over the last quarter of a one-shot run, dropping at expiry
    start0(16, 1'b0, e0);
    expect_tick(0, e0 + 16, 1'b1);
    for (int k = 1; k <= 16; k++) begin
      step(1);
      check("warn_level", warn[0], (k >= 12 && k < 16) ? 1 : 0);
    end
    stop0();
    drain("drain_warn");
`endif

    // four independent periodic channels, then asynchronous reset mid-count
    set_term(0, 3);
    set_term(1, 7);
    set_term(2, 11);
    set_term(3, 13);
    periodic = '1;
    en  = '1;
    clr = '1;
    e0 = edges + 1;
    step(1);
    clr = '0;
    l = $urandom_range(30, 60);
    for (int ch = 0; ch < NCH; ch++) begin
      te = (ch == 0) ? 3 : ((ch == 1) ? 7 : ((ch == 2) ? 11 : 13));
      for (int k = 1; k * te <= l; k++) expect_tick(ch, e0 + k * te, 1'b0);
    end
    step(l);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_full", full, 0);
    check("async_rst_tick", tick, 0);
    drain("drain_multi");
    en = '0;
    step(2);
    rst_n = 1'b1;
    step(3);
    check("post_rst_tick", tick, 0);
    check("post_rst_full", full, 0);

    drain("drain_final");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
